// File: rtl/dtc_seq_tree_walker.sv
// Sequential decision-tree classifier: walks one tree level per clock over a programmable node/leaf table.
// Optional macro DTC_PATH_TRACE_EN adds a path_trace output holding the branch bits of the last walk.
module dtc_seq_tree_walker #(
    parameter int N_FEAT = 12,
    parameter int DEPTH  = 4,
    parameter int FIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [DEPTH:0]    cfg_addr,
    input  logic [FIDX_W-1:0] cfg_wdata,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] inp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              outp
`ifdef DTC_PATH_TRACE_EN
    ,
    output logic [DEPTH-1:0]  path_trace
`endif
);

    localparam int N_NODE = (1 << DEPTH) - 1;
    localparam int N_LEAF = 1 << DEPTH;
    localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t            state;
    logic [FIDX_W-1:0] node_tbl [N_NODE];
    // Leaves are indexed by their config address, which equals the heap child index plus one.
    logic              leaf_tbl [N_LEAF:2*N_LEAF-1];
    logic [N_FEAT-1:0] sample;
    logic [DEPTH-1:0]  node_idx;
    logic [LVL_W-1:0]  level;

    logic [FIDX_W-1:0] fidx;
    logic              branch;
    logic [DEPTH:0]    child;
    logic [DEPTH:0]    leaf_addr;
    logic              addr_is_node;
    logic              addr_is_leaf;
    logic              cfg_ok;

    // Feature indices beyond the sample width read as 0.
    function automatic logic pick_bit(input logic [N_FEAT-1:0] s, input logic [FIDX_W-1:0] f);
        pick_bit = 1'b0;
        for (int k = 0; k < N_FEAT; k++)
            if (int'(f) == k) pick_bit = s[k];
    endfunction

    always_comb begin
        fidx         = node_tbl[node_idx];
        branch       = pick_bit(sample, fidx);
        child        = {node_idx, 1'b0} + (DEPTH+1)'(1) + (DEPTH+1)'(branch);
        leaf_addr    = child + (DEPTH+1)'(1);
        addr_is_node = cfg_addr < (DEPTH+1)'(N_NODE);
        addr_is_leaf = cfg_addr >= (DEPTH+1)'(N_LEAF);
        cfg_ok       = cfg_we && (state == IDLE) && (addr_is_node || addr_is_leaf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outp      <= 1'b0;
            cfg_err   <= 1'b0;
            sample    <= '0;
            node_idx  <= '0;
            level     <= '0;
            for (int i = 0; i < N_NODE; i++) node_tbl[i] <= '0;
            for (int i = N_LEAF; i < 2*N_LEAF; i++) leaf_tbl[i] <= 1'b0;
`ifdef DTC_PATH_TRACE_EN
            path_trace <= '0;
`endif
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                if (addr_is_node) node_tbl[cfg_addr[DEPTH-1:0]] <= cfg_wdata;
                else              leaf_tbl[cfg_addr] <= cfg_wdata[0];
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample   <= inp;
                        node_idx <= '0;
                        level    <= '0;
                        in_ready <= 1'b0;
                        state    <= WALK;
`ifdef DTC_PATH_TRACE_EN
                        path_trace <= '0;
`endif
                    end
                end
                WALK: begin
`ifdef DTC_PATH_TRACE_EN
                    path_trace <= {path_trace[DEPTH-2:0], branch};
`endif
                    if (level == LVL_W'(DEPTH-1)) begin
                        outp      <= leaf_tbl[leaf_addr];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        node_idx <= child[DEPTH-1:0];
                        level    <= level + LVL_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
